cache_set_array: RTL and testbench

Parametrised N-way set-associative cache storage: tag array ({valid, used, dirty, tag} per way) and data array (block per way) with built-in lookup, hit detection, NRU replacement, dirty-victim eviction and a clear sweep. It is the next-generation replacement for the fixed two-way tag/data RAM pairs. It sits between the cache controller FSM and main-memory write-back logic. One request is processed every two cycles.

---
 rtl/cache_set_array.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_cache_set_array.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_set_array.sv
// cache_set_array: N-way set-associative tag/data storage.
// Handles lookup, hit detection, NRU replacement, dirty-victim eviction
// and a clear sweep. Requests are accepted in IDLE, looked up in COMPARE,
// and answered with a registered one-cycle response.
module cache_set_array #(
   parameter int WAYS             = 2,
   parameter int INDEX_BIT        = 10,
   parameter int TAG_BIT          = 20,
   parameter int BLOCK_SIZE_WORDS = 4,
   localparam int WAY_BIT   = (WAYS > 2) ? $clog2(WAYS) : 1,
   localparam int WORD_BIT  = (BLOCK_SIZE_WORDS > 2) ? $clog2(BLOCK_SIZE_WORDS) : 1,
   localparam int BLOCK_BIT = 32 * BLOCK_SIZE_WORDS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [1:0]           req_op_i,
   input  logic [INDEX_BIT-1:0] req_index_i,
   input  logic [TAG_BIT-1:0]   req_tag_i,
   input  logic [WORD_BIT-1:0]  req_word_i,
   input  logic [31:0]          req_wdata_i,
   input  logic [BLOCK_BIT-1:0] req_fill_data_i,
   output logic                 resp_valid_o,
   output logic                 resp_hit_o,
   output logic [WAY_BIT-1:0]   resp_way_o,
   output logic [31:0]          resp_rdata_o,
   output logic                 evict_valid_o,
   output logic [TAG_BIT-1:0]   evict_tag_o,
   output logic [BLOCK_BIT-1:0] evict_data_o,
   input  logic                 clear_start_i,
   output logic                 clear_busy_o
);

   localparam int LINES     = 1 << INDEX_BIT;
   localparam int ENTRY_BIT = TAG_BIT + 3;

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_FILL  = 2'b10;
   localparam logic [1:0] OP_INV   = 2'b11;

   typedef enum logic [1:0] {INIT, IDLE, COMPARE, CLEAR} state_e;

   state_e                 state_q, state_d;
   logic [INDEX_BIT-1:0]   sweepIdx_q, sweepIdx_d;
   logic                   accept;

   logic [1:0]             reqOp_q;
   logic [INDEX_BIT-1:0]   reqIndex_q;
   logic [TAG_BIT-1:0]     reqTag_q;
   logic [WORD_BIT-1:0]    reqWord_q;
   logic [31:0]            reqWdata_q;
   logic [BLOCK_BIT-1:0]   reqFill_q;

   // Entry layout is {valid, used, dirty, tag}
   logic [ENTRY_BIT-1:0]   tagMem  [LINES][WAYS];
   logic [BLOCK_BIT-1:0]   dataMem [LINES][WAYS];

   logic [WAYS-1:0]        validVec, usedVec, dirtyVec, hitVec;
   logic [TAG_BIT-1:0]     wayTag  [WAYS];
   logic [BLOCK_BIT-1:0]   wayData [WAYS];
   logic                   hitAny;
   logic [WAY_BIT-1:0]     hitWay, victimWay, targetWay;
   logic                   victimFound;

   logic [WAYS-1:0]        validNext, usedNext, dirtyNext, touchMask;
   logic [TAG_BIT-1:0]     tagNext   [WAYS];
   logic [ENTRY_BIT-1:0]   entryNext [WAYS];
   logic                   tagWe, dataWe, touchEn;
   logic [WAY_BIT-1:0]     dataWay, touchWay;
   logic [BLOCK_BIT-1:0]   dataNext;
   logic [31:0]            rdata_d;
   logic                   evictValid_d;
   logic [TAG_BIT-1:0]     evictTag_d;
   logic [BLOCK_BIT-1:0]   evictData_d;
   int                     wordLsb;

   logic                   respValid_q, respHit_q, evictValid_q;
   logic [WAY_BIT-1:0]     respWay_q;
   logic [31:0]            respRdata_q;
   logic [TAG_BIT-1:0]     evictTag_q;
   logic [BLOCK_BIT-1:0]   evictData_q;

   // State and sweep counter; reset restarts the init sweep from index 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= INIT;
         sweepIdx_q <= '0;
      end else begin
         state_q    <= state_d;
         sweepIdx_q <= sweepIdx_d;
      end
   end

   // Next-state logic; clear_start wins over a request in the same IDLE cycle
   always_comb begin
      state_d    = state_q;
      sweepIdx_d = sweepIdx_q;
      accept     = 1'b0;
      case (state_q)
         INIT, CLEAR: begin
            sweepIdx_d = sweepIdx_q + 1'b1;
            if (sweepIdx_q == '1) state_d = IDLE;
         end
         IDLE: begin
            if (clear_start_i) begin
               state_d    = CLEAR;
               sweepIdx_d = '0;
            end else if (req_valid_i) begin
               accept  = 1'b1;
               state_d = COMPARE;
            end
         end
         COMPARE: state_d = IDLE;
         default: state_d = INIT;
      endcase
   end

   // Capture the request on handshake so COMPARE works from stable values
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reqOp_q    <= '0;
         reqIndex_q <= '0;
         reqTag_q   <= '0;
         reqWord_q  <= '0;
         reqWdata_q <= '0;
         reqFill_q  <= '0;
      end else if (accept) begin
         reqOp_q    <= req_op_i;
         reqIndex_q <= req_index_i;
         reqTag_q   <= req_tag_i;
         reqWord_q  <= req_word_i;
         reqWdata_q <= req_wdata_i;
         reqFill_q  <= req_fill_data_i;
      end
   end

   // Unpack every way of the addressed set and compare tags
   always_comb begin
      for (int w = 0; w < WAYS; w++) begin
         validVec[w] = tagMem[reqIndex_q][w][TAG_BIT+2];
         usedVec[w]  = tagMem[reqIndex_q][w][TAG_BIT+1];
         dirtyVec[w] = tagMem[reqIndex_q][w][TAG_BIT];
         wayTag[w]   = tagMem[reqIndex_q][w][TAG_BIT-1:0];
         wayData[w]  = dataMem[reqIndex_q][w];
         hitVec[w]   = validVec[w] && (wayTag[w] == reqTag_q);
      end
   end

   assign hitAny = |hitVec;

   // Lowest hit way, and victim: first invalid, else first not-used, else way 0
   always_comb begin
      hitWay      = '0;
      victimWay   = '0;
      victimFound = 1'b0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (hitVec[w]) hitWay = WAY_BIT'(w);
      end
      for (int w = 0; w < WAYS; w++) begin
         if (!victimFound && !validVec[w]) begin
            victimWay   = WAY_BIT'(w);
            victimFound = 1'b1;
         end
      end
      for (int w = 0; w < WAYS; w++) begin
         if (!victimFound && !usedVec[w]) begin
            victimWay   = WAY_BIT'(w);
            victimFound = 1'b1;
         end
      end
   end

   assign targetWay = hitAny ? hitWay : victimWay;

   // Per-op set update, NRU touch and response/eviction values
   always_comb begin
      validNext    = validVec;
      usedNext     = usedVec;
      dirtyNext    = dirtyVec;
      touchMask    = '0;
      tagWe        = 1'b0;
      dataWe       = 1'b0;
      touchEn      = 1'b0;
      touchWay     = hitWay;
      dataWay      = hitWay;
      dataNext     = wayData[hitWay];
      rdata_d      = '0;
      evictValid_d = 1'b0;
      evictTag_d   = '0;
      evictData_d  = '0;
      wordLsb      = 32 * int'(reqWord_q);
      for (int w = 0; w < WAYS; w++) tagNext[w] = wayTag[w];
      case (reqOp_q)
         OP_READ: begin
            if (hitAny) begin
               rdata_d = wayData[hitWay][wordLsb +: 32];
               tagWe   = 1'b1;
               touchEn = 1'b1;
            end
         end
         OP_WRITE: begin
            if (hitAny) begin
               dataNext[wordLsb +: 32] = reqWdata_q;
               dataWe             = 1'b1;
               dirtyNext[hitWay]  = 1'b1;
               tagWe              = 1'b1;
               touchEn            = 1'b1;
            end
         end
         OP_FILL: begin
            tagWe                = 1'b1;
            dataWe               = 1'b1;
            touchEn              = 1'b1;
            touchWay             = targetWay;
            dataWay              = targetWay;
            dataNext             = reqFill_q;
            validNext[targetWay] = 1'b1;
            dirtyNext[targetWay] = 1'b0;
            tagNext[targetWay]   = reqTag_q;
            if (validVec[targetWay] && dirtyVec[targetWay] && (wayTag[targetWay] != reqTag_q)) begin
               evictValid_d = 1'b1;
               evictTag_d   = wayTag[targetWay];
               evictData_d  = wayData[targetWay];
            end
         end
         OP_INV: begin
            if (hitAny) begin
               tagWe             = 1'b1;
               validNext[hitWay] = 1'b0;
               usedNext[hitWay]  = 1'b0;
               dirtyNext[hitWay] = 1'b0;
               if (dirtyVec[hitWay]) begin
                  evictValid_d = 1'b1;
                  evictTag_d   = wayTag[hitWay];
                  evictData_d  = wayData[hitWay];
               end
            end
         end
      endcase
      if (touchEn) begin
         touchMask[touchWay] = 1'b1;
         usedNext = usedNext | touchMask;
         if (&usedNext) usedNext = touchMask;
      end
      for (int w = 0; w < WAYS; w++) begin
         entryNext[w] = {validNext[w], usedNext[w], dirtyNext[w], tagNext[w]};
      end
   end

   // Array writes: sweeps zero tag entries, COMPARE commits the set update
   always_ff @(posedge clk) begin
      if (state_q == INIT || state_q == CLEAR) begin
         for (int w = 0; w < WAYS; w++) tagMem[sweepIdx_q][w] <= '0;
      end else if (state_q == COMPARE) begin
         if (tagWe) begin
            for (int w = 0; w < WAYS; w++) tagMem[reqIndex_q][w] <= entryNext[w];
         end
         if (dataWe) dataMem[reqIndex_q][dataWay] <= dataNext;
      end
   end

   // Registered one-cycle response; outputs read zero when not responding
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         respValid_q  <= 1'b0;
         respHit_q    <= 1'b0;
         respWay_q    <= '0;
         respRdata_q  <= '0;
         evictValid_q <= 1'b0;
         evictTag_q   <= '0;
         evictData_q  <= '0;
      end else if (state_q == COMPARE) begin
         respValid_q  <= 1'b1;
         respHit_q    <= hitAny;
         respWay_q    <= targetWay;
         respRdata_q  <= rdata_d;
         evictValid_q <= evictValid_d;
         evictTag_q   <= evictTag_d;
         evictData_q  <= evictData_d;
      end else begin
         respValid_q  <= 1'b0;
         respHit_q    <= 1'b0;
         respWay_q    <= '0;
         respRdata_q  <= '0;
         evictValid_q <= 1'b0;
         evictTag_q   <= '0;
         evictData_q  <= '0;
      end
   end

   assign req_ready_o   = (state_q == IDLE);
   assign clear_busy_o  = (state_q == INIT) || (state_q == CLEAR);
   assign resp_valid_o  = respValid_q;
   assign resp_hit_o    = respHit_q;
   assign resp_way_o    = respWay_q;
   assign resp_rdata_o  = respRdata_q;
   assign evict_valid_o = evictValid_q;
   assign evict_tag_o   = evictTag_q;
   assign evict_data_o  = evictData_q;

endmodule

// File: tb/tb_cache_set_array.sv
// Testbench for cache_set_array: directed walk-through plus randomized
// traffic, with a queue-based scoreboard fed from a set-level reference model.
module tb_cache_set_array;

   localparam int WAYS = 4;
   localparam int INDEX_BIT = 4;
   localparam int TAG_BIT = 8;
   localparam int BSW = 4;
   localparam int LINES = 16;

   logic         clk, rst;
   logic         req_valid, req_ready, clear_start, clear_busy;
   logic [1:0]   req_op;
   logic [3:0]   req_index;
   logic [7:0]   req_tag;
   logic [1:0]   req_word;
   logic [31:0]  req_wdata;
   logic [127:0] req_fill_data;
   logic         resp_valid, resp_hit, evict_valid;
   logic [1:0]   resp_way;
   logic [31:0]  resp_rdata;
   logic [7:0]   evict_tag;
   logic [127:0] evict_data;

   cache_set_array #(.WAYS(WAYS), .INDEX_BIT(INDEX_BIT), .TAG_BIT(TAG_BIT), .BLOCK_SIZE_WORDS(BSW)) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
      .req_index_i(req_index), .req_tag_i(req_tag), .req_word_i(req_word),
      .req_wdata_i(req_wdata), .req_fill_data_i(req_fill_data),
      .resp_valid_o(resp_valid), .resp_hit_o(resp_hit), .resp_way_o(resp_way),
      .resp_rdata_o(resp_rdata), .evict_valid_o(evict_valid), .evict_tag_o(evict_tag),
      .evict_data_o(evict_data), .clear_start_i(clear_start), .clear_busy_o(clear_busy)
   );

   typedef struct packed {
      logic         hit;
      logic [1:0]   way;
      logic [31:0]  rdata;
      logic         ev;
      logic [7:0]   evTag;
      logic [127:0] evData;
      int           cyc;
   } exp_t;

   exp_t expQ[$];
   exp_t monExp;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   // Reference model state: one record per (set, way)
   bit           mValid [LINES][WAYS];
   bit           mUsed  [LINES][WAYS];
   bit           mDirty [LINES][WAYS];
   logic [7:0]   mTag   [LINES][WAYS];
   logic [127:0] mData  [LINES][WAYS];

   // Free-running clock and cycle counter used to check response latency
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Scoreboard monitor: compare every presented response against the queue head
   always @(negedge clk) begin
      if (!rst) begin
         if (resp_valid) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_resp", 1, 0);
            end else begin
               monExp = expQ.pop_front();
               checkOutput("resp_cycle", cyc, monExp.cyc);
               checkOutput("resp_hit", resp_hit, monExp.hit);
               checkOutput("resp_way", resp_way, monExp.way);
               checkOutput("resp_rdata", resp_rdata, monExp.rdata);
               checkOutput("evict_valid", evict_valid, monExp.ev);
               if (monExp.ev) begin
                  checkOutput("evict_tag", evict_tag, monExp.evTag);
                  checkOutput("evict_data", evict_data, monExp.evData);
               end
            end
         end else if (evict_valid) begin
            checkOutput("stray_evict", 1, 0);
         end
      end
   end

   task automatic modelClear();
      for (int s = 0; s < LINES; s++)
         for (int w = 0; w < WAYS; w++) begin
            mValid[s][w] = 0; mUsed[s][w] = 0; mDirty[s][w] = 0;
         end
   endtask

   task automatic modelTouch(input int s, input int w);
      bit all;
      mUsed[s][w] = 1;
      all = 1;
      for (int v = 0; v < WAYS; v++) if (!mUsed[s][v]) all = 0;
      if (all) for (int v = 0; v < WAYS; v++) mUsed[s][v] = (v == w);
   endtask

   task automatic modelApply(input logic [1:0] op, input int s, input logic [7:0] tag,
                             input int word, input logic [31:0] wdata,
                             input logic [127:0] fill, output exp_t e);
      int hw, vw, tw;
      logic [127:0] blk;
      hw = -1; vw = -1;
      for (int w = 0; w < WAYS; w++) if (hw < 0 && mValid[s][w] && mTag[s][w] == tag) hw = w;
      for (int w = 0; w < WAYS; w++) if (vw < 0 && !mValid[s][w]) vw = w;
      for (int w = 0; w < WAYS; w++) if (vw < 0 && !mUsed[s][w]) vw = w;
      if (vw < 0) vw = 0;
      e = '0;
      e.hit = (hw >= 0);
      e.way = 2'(e.hit ? hw : vw);
      case (op)
         2'b00: if (e.hit) begin
            blk = mData[s][hw];
            e.rdata = blk[32*word +: 32];
            modelTouch(s, hw);
         end
         2'b01: if (e.hit) begin
            blk = mData[s][hw];
            blk[32*word +: 32] = wdata;
            mData[s][hw] = blk;
            mDirty[s][hw] = 1;
            modelTouch(s, hw);
         end
         2'b10: begin
            tw = e.hit ? hw : vw;
            if (mValid[s][tw] && mDirty[s][tw] && mTag[s][tw] != tag) begin
               e.ev = 1; e.evTag = mTag[s][tw]; e.evData = mData[s][tw];
            end
            mValid[s][tw] = 1; mDirty[s][tw] = 0; mTag[s][tw] = tag; mData[s][tw] = fill;
            modelTouch(s, tw);
         end
         default: if (e.hit) begin
            if (mDirty[s][hw]) begin
               e.ev = 1; e.evTag = mTag[s][hw]; e.evData = mData[s][hw];
            end
            mValid[s][hw] = 0; mUsed[s][hw] = 0; mDirty[s][hw] = 0;
         end
      endcase
   endtask

   function automatic exp_t mk(input logic hit, input logic [1:0] way, input logic [31:0] rdata,
                               input logic ev, input logic [7:0] evTag, input logic [127:0] evData);
      exp_t e;
      e = '0;
      e.hit = hit; e.way = way; e.rdata = rdata; e.ev = ev; e.evTag = evTag; e.evData = evData;
      return e;
   endfunction

   // Wait (bounded) at a negedge until the DUT is ready
   task automatic waitReady(output bit ok);
      int n;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      ok = req_ready;
      if (!ok) checkOutput("ready_timeout", 0, 1);
   endtask

   // Issue one request; expected response comes from the model unless given explicitly
   task automatic applyStimulus(input logic [1:0] op, input int s, input logic [7:0] tag,
                                input int word, input logic [31:0] wdata, input logic [127:0] fill,
                                input bit useGiven, input exp_t given);
      exp_t e;
      bit ok;
      waitReady(ok);
      if (ok) begin
         req_valid = 1; req_op = op; req_index = 4'(s); req_tag = tag;
         req_word = 2'(word); req_wdata = wdata; req_fill_data = fill; clear_start = 0;
         @(posedge clk);
         #1;
         modelApply(op, s, tag, word, wdata, fill, e);
         if (useGiven) e = given;
         e.cyc = cyc + 1;
         expQ.push_back(e);
         req_valid = 0;
      end
   endtask

   // Count busy cycles of a sweep and check the ready behaviour around it
   task automatic countSweep(input string name);
      int n;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!clear_busy) break;
         n++;
         if (req_ready) checkOutput({name, "_ready_busy"}, req_ready, 0);
      end
      checkOutput({name, "_busy_cycles"}, n, LINES);
      checkOutput({name, "_ready_after"}, req_ready, 1);
   endtask

   task automatic clearWithRequest();
      bit ok;
      waitReady(ok);
      if (ok) begin
         clear_start = 1; req_valid = 1; req_op = 2'b00; req_index = 4'd3; req_tag = 8'h30;
         @(posedge clk);
         #1;
         clear_start = 0; req_valid = 0;
         modelClear();
         countSweep("clear");
      end
   endtask

   localparam logic [127:0] BLK3 = 128'h000000A3_000000A2_000000A1_000000A0;
   localparam logic [127:0] EV3  = 128'h000000A3_000000A2_0000DEAD_000000A0;
   localparam logic [127:0] BLK5 = 128'h00000B03_00000B02_00000B01_00000B00;
   localparam logic [127:0] EV5  = 128'h00000B03_00000B02_00000B01_0000BEEF;

   initial begin
      exp_t none;
      bit ok;
      int n;
      none = '0;
      rst = 1; req_valid = 0; req_op = 0; req_index = 0; req_tag = 0; req_word = 0;
      req_wdata = 0; req_fill_data = 0; clear_start = 0;
      modelClear();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_req_ready", req_ready, 0);
      checkOutput("rst_resp_valid", resp_valid, 0);
      checkOutput("rst_evict_valid", evict_valid, 0);
      checkOutput("rst_clear_busy", clear_busy, 1);
      checkOutput("rst_resp_rdata", resp_rdata, 0);
      checkOutput("rst_evict_data", evict_data, 0);
      @(posedge clk);
      #1 rst = 0;
      countSweep("init");

      // Cold miss, fill, read back
      applyStimulus(2'b00, 3, 8'h12, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0));
      applyStimulus(2'b10, 3, 8'h12, 0, 0, BLK3, 1, mk(0, 0, 0, 0, 0, 0));
      applyStimulus(2'b00, 3, 8'h12, 2, 0, 0, 1, mk(1, 0, 32'hA2, 0, 0, 0));
      // Dirty the line, fill the rest of the set, then displace it
      applyStimulus(2'b01, 3, 8'h12, 1, 32'hDEAD, 0, 1, mk(1, 0, 0, 0, 0, 0));
      applyStimulus(2'b10, 3, 8'h20, 0, 0, 128'h20, 1, mk(0, 1, 0, 0, 0, 0));
      applyStimulus(2'b10, 3, 8'h21, 0, 0, 128'h21, 1, mk(0, 2, 0, 0, 0, 0));
      applyStimulus(2'b10, 3, 8'h22, 0, 0, 128'h22, 1, mk(0, 3, 0, 0, 0, 0));
      applyStimulus(2'b10, 3, 8'h30, 0, 0, 128'h30, 1, mk(0, 0, 0, 1, 8'h12, EV3));
      // No write-allocate
      applyStimulus(2'b01, 3, 8'h55, 0, 32'h1234, 0, 1, mk(0, 1, 0, 0, 0, 0));
      applyStimulus(2'b00, 3, 8'h55, 0, 0, 0, 1, mk(0, 1, 0, 0, 0, 0));
      // Invalidate of a dirty line evicts it; a second invalidate misses
      applyStimulus(2'b10, 5, 8'h40, 0, 0, BLK5, 1, mk(0, 0, 0, 0, 0, 0));
      applyStimulus(2'b01, 5, 8'h40, 0, 32'hBEEF, 0, 1, mk(1, 0, 0, 0, 0, 0));
      applyStimulus(2'b11, 5, 8'h40, 0, 0, 0, 1, mk(1, 0, 0, 1, 8'h40, EV5));
      applyStimulus(2'b00, 5, 8'h40, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0));
      applyStimulus(2'b11, 5, 8'h40, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0));
      // Clear beats a simultaneous request; everything misses afterwards
      clearWithRequest();
      applyStimulus(2'b00, 3, 8'h30, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0));
      applyStimulus(2'b00, 3, 8'h22, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0));

      // Reset during COMPARE drops the request and restarts the init sweep
      waitReady(ok);
      if (ok) begin
         req_valid = 1; req_op = 2'b10; req_index = 4'd7; req_tag = 8'h77; req_fill_data = 128'h77;
         @(posedge clk);
         #1 req_valid = 0;
         @(negedge clk);
         rst = 1;
         #1 checkOutput("rst_drop_resp", resp_valid, 0);
         @(negedge clk);
         checkOutput("rst_no_resp", resp_valid, 0);
         checkOutput("rst_busy", clear_busy, 1);
         @(posedge clk);
         #1 rst = 0;
         modelClear();
         countSweep("reinit");
         applyStimulus(2'b00, 7, 8'h77, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0));
      end

      // Randomized traffic against the reference model
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 99) < 2) begin
            clearWithRequest();
         end else begin
            applyStimulus(2'($urandom_range(0, 3)), $urandom_range(0, 3),
                          8'h10 + 8'($urandom_range(0, 5)), $urandom_range(0, 3), $urandom,
                          {$urandom, $urandom, $urandom, $urandom}, 0, none);
         end
      end

      n = 0;
      while (expQ.size() > 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (expQ.size() > 0) checkOutput("drain", expQ.size(), 0);
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
